csb_master_arbiter: RTL

- Shares one CSB master port between NUM_REQ requesters, e.g. a firmware-model driver and a register-sequence replayer in a CSB test harness, or multiple CSB initiators in the DUT top.
- Uses round-robin arbitration with a single outstanding transaction.
- Routes each read response (rvld/rdata) or non-posted write completion (wr_complete) back to the requester that issued it.
- Includes a response timeout that synthesizes a response so a hung slave cannot lock the port.

---
 rtl/csb_master_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/csb_master_arbiter.sv
// Round-robin arbiter sharing one CSB master port among NUM_REQ requesters.
// One outstanding transaction, routed responses and a response timeout.
module csb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_pvld,
  output logic [NUM_REQ-1:0]            req_prdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_nposted,
  output logic [NUM_REQ-1:0]            req_rvld,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]            req_wr_complete,
  output logic                          csb_pvld,
  input  logic                          csb_prdy,
  output logic [ADDR_WIDTH-1:0]         csb_addr,
  output logic                          csb_write,
  output logic [DATA_WIDTH-1:0]         csb_wdata,
  output logic                          csb_nposted,
  input  logic                          csb_rvld,
  input  logic [DATA_WIDTH-1:0]         csb_rdata,
  input  logic                          csb_wr_complete,
  output logic                          timeout_pulse,
  output logic                          spurious_pulse
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT
  } state_t;

  state_t state;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      owner;
  logic [PW-1:0]      win;
  logic [PW-1:0]      win_nxt;
  logic               found;
  logic [CW-1:0]      cnt;
  logic               is_rd;
  logic               rsp_ok;
  logic               rsp_bad;
  logic               expire;
  logic [NUM_REQ-1:0] own_oh;

  // First asserted requester at or after rr_ptr, wrapping.
  always_comb begin
    logic [PW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_pvld[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_nxt =
    (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  assign is_rd  = !csb_write;
  assign own_oh = NUM_REQ'(1) << owner;

  assign rsp_ok = (state == S_WAIT) &&
    (is_rd ? csb_rvld : csb_wr_complete);

  assign rsp_bad = (state == S_WAIT) ?
    (is_rd ? csb_wr_complete : csb_rvld) :
    (csb_rvld || csb_wr_complete);

  assign expire = (TIMEOUT != 0) &&
    (state == S_WAIT) && (cnt == TO_LAST) && !rsp_ok;

  assign req_prdy = (rst_n && state == S_IDLE && found) ?
    (NUM_REQ'(1) << win) : '0;

  // timeout_pulse doubles as the synthesized-response strobe.
  assign req_rvld = ((rsp_ok || timeout_pulse) && is_rd) ?
    own_oh : '0;

  assign req_wr_complete = ((rsp_ok || timeout_pulse) && !is_rd) ?
    own_oh : '0;

  assign req_rdata = !rst_n ? '0 :
    (timeout_pulse && is_rd) ? TIMEOUT_DATA : csb_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      cnt            <= '0;
      csb_pvld       <= 1'b0;
      csb_addr       <= '0;
      csb_write      <= 1'b0;
      csb_wdata      <= '0;
      csb_nposted    <= 1'b0;
      timeout_pulse  <= 1'b0;
      spurious_pulse <= 1'b0;
    end else begin
      timeout_pulse  <= 1'b0;
      spurious_pulse <= rsp_bad;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            csb_pvld    <= 1'b1;
            csb_addr    <= req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
            csb_write   <= req_write[win];
            csb_wdata   <= req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
            csb_nposted <= req_nposted[win] & req_write[win];
            owner       <= win;
            rr_ptr      <= win_nxt;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          if (csb_prdy) begin
            csb_pvld <= 1'b0;
            cnt      <= '0;
            if (!csb_write || csb_nposted) begin
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_WAIT: begin
          if (rsp_ok) begin
            state <= S_IDLE;
          end else if (expire) begin
            timeout_pulse <= 1'b1;
            state         <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
